// File: rtl/led_pio_blink.sv
// Avalon-MM LED PIO with per-channel blink gating driven by a programmable
// half-period prescaler; readback is combinational with zero wait states.
module led_pio_blink #(
    parameter int unsigned                WIDTH        = 8,
    parameter int unsigned                PERIOD_W     = 24,
    parameter logic [WIDTH-1:0]           RESET_DATA   = '0,
    parameter logic [PERIOD_W-1:0]        RESET_PERIOD = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [WIDTH-1:0]    out_port
);

    logic [WIDTH-1:0]    data_reg;
    logic [WIDTH-1:0]    blink_en;
    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] cnt;
    logic                phase;
    logic                wr_stb;
    logic                period_zero;
    logic [WIDTH-1:0]    wdata;
    logic                unused_wdata;

    assign wr_stb       = chipselect & ~write_n;
    assign period_zero  = (period_reg == '0);
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= RESET_DATA;
            blink_en <= '0;
        end else if (wr_stb) begin
            case (address)
                3'd0:    data_reg <= wdata;
                3'd1:    blink_en <= wdata;
                3'd4:    data_reg <= data_reg | wdata;
                3'd5:    data_reg <= data_reg & ~wdata;
                3'd6:    data_reg <= data_reg ^ wdata;
                default: ;
            endcase
        end
    end

    // A PERIOD write restarts the half-period with the LEDs in the on phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_reg <= RESET_PERIOD;
            cnt        <= RESET_PERIOD;
            phase      <= 1'b1;
        end else if (wr_stb && address == 3'd2) begin
            period_reg <= writedata[PERIOD_W-1:0];
            cnt        <= writedata[PERIOD_W-1:0];
            phase      <= 1'b1;
        end else if (period_zero) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == '0) begin
            cnt   <= period_reg;
            phase <= ~phase;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata[WIDTH-1:0]    = data_reg;
            3'd1:    readdata[WIDTH-1:0]    = blink_en;
            3'd2:    readdata[PERIOD_W-1:0] = period_reg;
            3'd3:    readdata[1:0]          = {period_zero, phase};
            default: readdata = '0;
        endcase
    end

    assign out_port = data_reg & (~blink_en | {WIDTH{phase}});

endmodule

// File: tb/tb_led_pio_blink.sv
// Directed plus randomized check of led_pio_blink against a cycle-count
// model: blink phase derived arithmetically from edges since the last restart.
module tb_led_pio_blink;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int unsigned vectors;
    int unsigned miscompares;

    logic [7:0]  m_data;
    logic [7:0]  m_blink;
    int unsigned m_period;
    int unsigned m_k;

    led_pio_blink #(
        .WIDTH        (8),
        .PERIOD_W     (24),
        .RESET_DATA   (8'h00),
        .RESET_PERIOD (24'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Phase is on for edges 0..P after a restart, off for the next P+1, and so on.
    function automatic logic exp_phase();
        if (m_period == 0)
            return 1'b1;
        return ((m_k / (m_period + 1)) % 2) == 0;
    endfunction

    function automatic logic [7:0] exp_out();
        return m_data & (~m_blink | {8{exp_phase()}});
    endfunction

    function automatic logic [31:0] exp_read(input int unsigned a);
        case (a)
            0:       return {24'b0, m_data};
            1:       return {24'b0, m_blink};
            2:       return m_period;
            3:       return {30'b0, (m_period == 0), exp_phase()};
            default: return 32'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; the 8 reads finish before the falling edge.
    task automatic check_all(input string tag);
        chk({tag, "_out"}, {24'b0, out_port}, {24'b0, exp_out()});
        for (int unsigned a = 0; a < 8; a++) begin
            address = a[2:0];
            #1;
            chk($sformatf("%s_rd%0d", tag, a), readdata, exp_read(a));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_k++;
    endtask

    task automatic wr_raw(input logic [2:0] a, input logic [31:0] d,
                          input logic cs, input logic wn);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = wn;
        @(posedge clk);
        #1;
        m_k++;
        if (cs && !wn) begin
            case (a)
                3'd0: m_data  = d[7:0];
                3'd1: m_blink = d[7:0];
                3'd2: begin
                    m_period = d & 32'h00FF_FFFF;
                    m_k      = 0;
                end
                3'd4: m_data = m_data | d[7:0];
                3'd5: m_data = m_data & ~d[7:0];
                3'd6: m_data = m_data ^ d[7:0];
                default: ;
            endcase
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_raw(a, d, 1'b1, 1'b0);
    endtask

    task automatic model_reset();
        m_data   = 8'h00;
        m_blink  = 8'h00;
        m_period = 0;
        m_k      = 0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        address     = '0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = '0;
        model_reset();

        // Reset state, including a write attempt that must be ignored.
        @(posedge clk);
        #1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'hFF;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        check_all("reset");
        #4 reset = 1'b0;

        wr(3'd0, 32'hA5);
        check_all("data_a5");

        wr(3'd0, 32'hF0);
        wr(3'd4, 32'h0F);
        check_all("set");
        wr(3'd5, 32'h81);
        check_all("clear");
        wr(3'd6, 32'hFF);
        check_all("toggle");
        wr_raw(3'd0, 32'h00, 1'b0, 1'b0);
        check_all("cs_low");
        wr_raw(3'd6, 32'hFF, 1'b1, 1'b1);
        check_all("wn_high");
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        check_all("ro_reserved");

        // Period 3: bit0 blinks 4 on / 4 off, bit1 steady.
        wr(3'd0, 32'h03);
        wr(3'd1, 32'h01);
        wr(3'd2, 32'd3);
        check_all("p3_start");
        for (int unsigned n = 0; n < 17; n++) begin
            tick();
            check_all($sformatf("p3_c%0d", n));
        end

        for (int unsigned n = 0; n < 20 && exp_phase() != 1'b0; n++)
            tick();
        check_all("p3_phase0");
        wr(3'd2, 32'd5);
        check_all("p5_restart");
        for (int unsigned n = 0; n < 14; n++) begin
            tick();
            check_all($sformatf("p5_c%0d", n));
        end

        wr(3'd2, 32'd0);
        wr(3'd1, 32'hFF);
        wr(3'd0, 32'h55);
        for (int unsigned n = 0; n < 4; n++) begin
            tick();
            check_all($sformatf("p0_c%0d", n));
        end

        // Asynchronous reset between edges while blinking.
        wr(3'd2, 32'd2);
        wr(3'd0, 32'hC3);
        wr(3'd1, 32'hFF);
        for (int unsigned n = 0; n < 4; n++)
            tick();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        #5 reset = 1'b0;
        tick();
        check_all("post_rst");

        for (int unsigned i = 0; i < 150; i++) begin
            int unsigned op;
            int unsigned ctrl;
            logic [2:0]  a;
            logic [31:0] d;
            op = $urandom_range(0, 9);
            if (op < 6) begin
                a    = 3'($urandom_range(0, 7));
                d    = $urandom;
                if (a == 3'd2)
                    d = (d & 32'hFF00_0000) | $urandom_range(0, 6);
                ctrl = $urandom_range(0, 3);
                case (ctrl)
                    0:       wr_raw(a, d, 1'b0, 1'b0);
                    1:       wr_raw(a, d, 1'b1, 1'b1);
                    default: wr(a, d);
                endcase
            end else begin
                ctrl = $urandom_range(1, 5);
                for (int unsigned n = 0; n < ctrl; n++)
                    tick();
            end
            check_all($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
